// File: rtl/text_plane_pkg.sv
// Shared definitions for the 16x32 character plane and its write clients.
// Holds plane dimensions and address widths, the control codes understood
// by the text writer, the blank character used by clears and backspace,
// and the writer state encoding.
package text_plane_pkg;

  localparam int ROW_NUMBER     = 16;
  localparam int COL_NUMBER     = 32;
  localparam int ROW_BIT_LEN    = 4;
  localparam int COL_BIT_LEN    = 5;
  localparam int CHAR_ID_LENGTH = 8;

  localparam logic [ROW_BIT_LEN-1:0] ROW_LAST = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] COL_LAST = COL_BIT_LEN'(COL_NUMBER - 1);

  localparam logic [CHAR_ID_LENGTH-1:0] BLANK_CHAR = 8'h20;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_BS    = 8'h08;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_LF    = 8'h0A;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_FF    = 8'h0C;
  localparam logic [CHAR_ID_LENGTH-1:0] CHAR_CR    = 8'h0D;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  // Printable range is 0x20 (space) through 0x7E (tilde).
  function automatic logic is_printable(input logic [CHAR_ID_LENGTH-1:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

// File: rtl/plane_clear_sweeper.sv
// Address counter for clearing the character plane, one cell per cycle.
// A start pulse loads either column 0 of start_row (row mode) or cell (0,0)
// (all mode). While a sweep runs, the internal index names the cell being
// written this cycle; next_row/next_col give the cell for the following
// cycle so a client can register its write address one cycle ahead.
// done is high during the final cell of the sweep.
// Ports:
//   clock, reset          clock and async active-high reset
//   start, mode_all       begin a sweep; mode_all selects whole-plane sweep
//   start_row             row to clear in row mode
//   done                  current cycle writes the last cell
//   next_row, next_col    address of the cell after the current one
module plane_clear_sweeper
  import text_plane_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   mode_all,
  input  logic [ROW_BIT_LEN-1:0] start_row,
  output logic                   done,
  output logic [ROW_BIT_LEN-1:0] next_row,
  output logic [COL_BIT_LEN-1:0] next_col
);

  localparam int IDX_W = ROW_BIT_LEN + COL_BIT_LEN;
  localparam logic [IDX_W-1:0] IDX_LAST = {IDX_W{1'b1}};

  logic [IDX_W-1:0] idx_q, idx_d, idx_next;
  logic             active_q, active_d;
  logic             all_q, all_d;

  // Row-major linear index: the upper bits are the row, the lower the column.
  assign idx_next = idx_q + 1'b1;
  assign next_row = idx_next[IDX_W-1:COL_BIT_LEN];
  assign next_col = idx_next[COL_BIT_LEN-1:0];
  assign done     = active_q && (all_q ? (idx_q == IDX_LAST)
                                       : (idx_q[COL_BIT_LEN-1:0] == COL_LAST));

  always_comb begin
    idx_d    = idx_q;
    active_d = active_q;
    all_d    = all_q;
    if (start) begin
      idx_d    = mode_all ? '0 : {start_row, {COL_BIT_LEN{1'b0}}};
      active_d = 1'b1;
      all_d    = mode_all;
    end else if (active_q) begin
      if (done) active_d = 1'b0;
      else      idx_d    = idx_next;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q    <= '0;
      active_q <= 1'b0;
      all_q    <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      active_q <= active_d;
      all_q    <= all_d;
    end
  end

endmodule

// File: rtl/text_plane_writer.sv
// Turns a character stream into writes on the character plane's write port.
// Keeps the text cursor, decodes LF/CR/BS/FF, and runs row or whole-plane
// clear sweeps through plane_clear_sweeper. All outputs are registered.
// Ports:
//   clock, reset                  clock and async active-high reset
//   in_char, in_valid, in_ready   character input handshake
//   plane_data/row/col/we         write port of the character plane
//   cursor_row, cursor_col        cursor position for the renderer
//   busy                          writer is not idle
module text_plane_writer
  import text_plane_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHAR_ID_LENGTH-1:0] in_char,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHAR_ID_LENGTH-1:0] plane_data,
  output logic [ROW_BIT_LEN-1:0]    plane_row,
  output logic [COL_BIT_LEN-1:0]    plane_col,
  output logic                      plane_we,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  state_t                    state_q, state_d;
  logic [ROW_BIT_LEN-1:0]    cursor_row_q, cursor_row_d;
  logic [COL_BIT_LEN-1:0]    cursor_col_q, cursor_col_d;
  logic                      wrapped_q, wrapped_d;
  logic                      bs_pending_q, bs_pending_d;
  logic                      in_ready_q, in_ready_d;
  logic                      busy_q, busy_d;
  logic                      plane_we_q, plane_we_d;
  logic [CHAR_ID_LENGTH-1:0] plane_data_q, plane_data_d;
  logic [ROW_BIT_LEN-1:0]    plane_row_q, plane_row_d;
  logic [COL_BIT_LEN-1:0]    plane_col_q, plane_col_d;

  logic                      sweep_start, sweep_all, sweep_done;
  logic [ROW_BIT_LEN-1:0]    sweep_row, sweep_next_row;
  logic [COL_BIT_LEN-1:0]    sweep_next_col;

  logic [ROW_BIT_LEN-1:0]    adv_row;
  logic                      adv_wrap;

  // Row advance wraps naturally at the row width; leaving the last row
  // marks the plane as wrapped so every later new line gets cleared.
  assign adv_row  = cursor_row_q + 1'b1;
  assign adv_wrap = (cursor_row_q == ROW_LAST);

  plane_clear_sweeper u_sweeper (
    .clock     (clock),
    .reset     (reset),
    .start     (sweep_start),
    .mode_all  (sweep_all),
    .start_row (sweep_row),
    .done      (sweep_done),
    .next_row  (sweep_next_row),
    .next_col  (sweep_next_col)
  );

  // Next-state and registered-output logic. Write-port values are computed
  // one cycle ahead so plane_we and the address appear in the write cycle.
  // A backspace records the blank's cell as the new cursor, applied at the
  // end of its WRITE cycle together with ordinary cursor advances.
  always_comb begin
    state_d      = state_q;
    cursor_row_d = cursor_row_q;
    cursor_col_d = cursor_col_q;
    wrapped_d    = wrapped_q;
    bs_pending_d = bs_pending_q;
    plane_we_d   = 1'b0;
    plane_data_d = plane_data_q;
    plane_row_d  = plane_row_q;
    plane_col_d  = plane_col_q;
    sweep_start  = 1'b0;
    sweep_all    = 1'b0;
    sweep_row    = adv_row;

    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (is_printable(in_char)) begin
            state_d      = WRITE;
            plane_we_d   = 1'b1;
            plane_data_d = in_char;
            plane_row_d  = cursor_row_q;
            plane_col_d  = cursor_col_q;
            bs_pending_d = 1'b0;
          end else begin
            case (in_char)
              CHAR_LF: begin
                cursor_col_d = '0;
                cursor_row_d = adv_row;
                if (adv_wrap) wrapped_d = 1'b1;
                if (adv_wrap || wrapped_q) begin
                  state_d      = CLEAR_ROW;
                  plane_we_d   = 1'b1;
                  plane_data_d = BLANK_CHAR;
                  plane_row_d  = adv_row;
                  plane_col_d  = '0;
                  sweep_start  = 1'b1;
                end
              end
              CHAR_CR: cursor_col_d = '0;
              CHAR_BS: begin
                if (cursor_col_q != '0 || cursor_row_q != '0) begin
                  state_d      = WRITE;
                  plane_we_d   = 1'b1;
                  plane_data_d = BLANK_CHAR;
                  bs_pending_d = 1'b1;
                  if (cursor_col_q != '0) begin
                    plane_row_d = cursor_row_q;
                    plane_col_d = cursor_col_q - 1'b1;
                  end else begin
                    plane_row_d = cursor_row_q - 1'b1;
                    plane_col_d = COL_LAST;
                  end
                end
              end
              CHAR_FF: begin
                state_d      = CLEAR_ALL;
                plane_we_d   = 1'b1;
                plane_data_d = BLANK_CHAR;
                plane_row_d  = '0;
                plane_col_d  = '0;
                sweep_start  = 1'b1;
                sweep_all    = 1'b1;
              end
              default: ;
            endcase
          end
        end
      end

      WRITE: begin
        state_d = IDLE;
        if (bs_pending_q) begin
          cursor_row_d = plane_row_q;
          cursor_col_d = plane_col_q;
        end else if (cursor_col_q == COL_LAST) begin
          cursor_col_d = '0;
          cursor_row_d = adv_row;
          if (adv_wrap) wrapped_d = 1'b1;
          if (adv_wrap || wrapped_q) begin
            state_d      = CLEAR_ROW;
            plane_we_d   = 1'b1;
            plane_data_d = BLANK_CHAR;
            plane_row_d  = adv_row;
            plane_col_d  = '0;
            sweep_start  = 1'b1;
          end
        end else begin
          cursor_col_d = cursor_col_q + 1'b1;
        end
      end

      CLEAR_ROW, CLEAR_ALL: begin
        if (sweep_done) begin
          state_d = IDLE;
          if (state_q == CLEAR_ALL) begin
            cursor_row_d = '0;
            cursor_col_d = '0;
            wrapped_d    = 1'b0;
          end
        end else begin
          plane_we_d   = 1'b1;
          plane_data_d = BLANK_CHAR;
          plane_row_d  = sweep_next_row;
          plane_col_d  = sweep_next_col;
        end
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State and output registers; reset abandons any sweep in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cursor_row_q <= '0;
      cursor_col_q <= '0;
      wrapped_q    <= 1'b0;
      bs_pending_q <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      plane_we_q   <= 1'b0;
      plane_data_q <= '0;
      plane_row_q  <= '0;
      plane_col_q  <= '0;
    end else begin
      state_q      <= state_d;
      cursor_row_q <= cursor_row_d;
      cursor_col_q <= cursor_col_d;
      wrapped_q    <= wrapped_d;
      bs_pending_q <= bs_pending_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      plane_we_q   <= plane_we_d;
      plane_data_q <= plane_data_d;
      plane_row_q  <= plane_row_d;
      plane_col_q  <= plane_col_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign plane_we   = plane_we_q;
  assign plane_data = plane_data_q;
  assign plane_row  = plane_row_q;
  assign plane_col  = plane_col_q;
  assign cursor_row = cursor_row_q;
  assign cursor_col = cursor_col_q;

endmodule
